obi_mem_dump: RTL and testbench

OBI manager that reads a contiguous word range back out of an SSRAM (through its `ssram_wrap` responder) after program execution and streams the words out on a valid/ready port. It is the read-back end of the memory-flashing path: the bench or a debug host uses it to extract the data memory image for comparison against a golden hex file.

---
 rtl/riscv_pkg.sv | 9 +
 rtl/obi_intf.sv | 23 ++
 rtl/dump_fifo.sv | 52 +++++
 rtl/obi_mem_dump.sv | 137 +++++++++++++
 tb/tb_obi_mem_dump.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the memory read-back (dump) path.
package riscv_pkg;

    typedef enum logic [1:0] {DUMP_IDLE, DUMP_REQ, DUMP_RESP, DUMP_DRAIN} dump_state_t;

    localparam int DUMP_FIFO_DEPTH = 2;
    localparam logic [3:0] OBI_BE_WORD = 4'hF;

endpackage

// File: rtl/obi_intf.sv
// OBI bus bundle between a manager and an SSRAM responder.
interface obi_intf;

    logic        req;
    logic        gnt;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        rvalid;
    logic [31:0] rdata;

    modport manager (
        output req, addr, we, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport subordinate (
        input  req, addr, we, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/dump_fifo.sv
// Two-entry FIFO holding a read word plus its end-of-dump marker.
module dump_fifo
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [32:0] wr_data,
    output logic [32:0] rd_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DUMP_FIFO_DEPTH);

    logic [32:0]   mem [DUMP_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    count;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int k = 0; k < DUMP_FIFO_DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign full    = (count == 2'(DUMP_FIFO_DEPTH));
    assign empty   = (count == 2'd0);
    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/obi_mem_dump.sv
// OBI manager that reads LEN words from BASE_ADDR and streams them on a valid/ready port.
// Optional running sum of accepted words on CHECKSUM when OBI_DUMP_CHECKSUM_EN is defined.
module obi_mem_dump
    import riscv_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LEN_W     = 11
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [LEN_W-1:0] LEN,
    obi_intf.manager         obi_intf_out,
    output logic [31:0]      DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic             DOUT_LAST,
    output logic             BUSY,
    output logic             DONE
`ifdef OBI_DUMP_CHECKSUM_EN
    ,
    output logic [31:0]      CHECKSUM
`endif
);

    dump_state_t      state;
    dump_state_t      state_n;
    logic [LEN_W-1:0] word_idx;
    logic [LEN_W-1:0] idx_next;
    logic [LEN_W-1:0] len_q;
    logic             rsp_seen;
    logic             zero_done;
    logic             obi_req;
    logic             push;
    logic             pop;
    logic             last_word;
    logic             slot_free;
    logic [32:0]      fifo_rd;
    logic             fifo_full;
    logic             fifo_empty;

    assign idx_next  = word_idx + LEN_W'(1);
    assign last_word = (idx_next == len_q);
    assign push      = (state == DUMP_RESP) && obi_intf_out.rvalid && !rsp_seen;
    assign pop       = DOUT_VALID && DOUT_READY;

    // Occupancy after this cycle stays below two, so a new read can never overflow the FIFO.
    assign slot_free = pop || !(fifo_full || (push && !fifo_empty));

    always_comb begin
        state_n = state;
        obi_req = 1'b0;
        case (state)
            DUMP_IDLE: begin
                if (START && (LEN != '0)) begin
                    state_n = DUMP_REQ;
                end
            end
            DUMP_REQ: begin
                obi_req = 1'b1;
                if (obi_intf_out.gnt) begin
                    state_n = DUMP_RESP;
                end
            end
            DUMP_RESP: begin
                if (push && last_word) begin
                    state_n = DUMP_DRAIN;
                end else if ((push || rsp_seen) && slot_free) begin
                    state_n = DUMP_REQ;
                end
            end
            DUMP_DRAIN: begin
                if (fifo_empty) begin
                    state_n = DUMP_IDLE;
                end
            end
            default: state_n = DUMP_IDLE;
        endcase
    end

    // rsp_seen marks a RESP cycle whose word is already buffered while waiting for credit.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= DUMP_IDLE;
            word_idx  <= '0;
            len_q     <= '0;
            rsp_seen  <= 1'b0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_n;
            zero_done <= (state == DUMP_IDLE) && START && (LEN == '0);
            rsp_seen  <= (state_n == DUMP_RESP) && (rsp_seen || push);
            if ((state == DUMP_IDLE) && START) begin
                word_idx <= '0;
                len_q    <= LEN;
            end else if (push) begin
                word_idx <= idx_next;
            end
        end
    end

    dump_fifo u_fifo (
        .clk     (CLK),
        .rst     (RST),
        .push    (push),
        .pop     (pop),
        .wr_data ({last_word, obi_intf_out.rdata}),
        .rd_data (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign obi_intf_out.req   = obi_req;
    assign obi_intf_out.addr  = BASE_ADDR + (32'(word_idx) << 2);
    assign obi_intf_out.we    = 1'b0;
    assign obi_intf_out.be    = OBI_BE_WORD;
    assign obi_intf_out.wdata = '0;

    assign DOUT       = fifo_rd[31:0];
    assign DOUT_LAST  = fifo_rd[32];
    assign DOUT_VALID = !fifo_empty;
    assign BUSY       = (state != DUMP_IDLE);
    assign DONE       = zero_done || ((state == DUMP_DRAIN) && fifo_empty);

`ifdef OBI_DUMP_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            CHECKSUM <= '0;
        end else if ((state == DUMP_IDLE) && START) begin
            CHECKSUM <= '0;
        end else if (pop) begin
            CHECKSUM <= CHECKSUM + DOUT;
        end
    end
`endif

endmodule

// File: tb/tb_obi_mem_dump.sv
// Randomized bench for obi_mem_dump: SSRAM responder model, stalling sink and per-scenario checks.
module tb_obi_mem_dump;

    logic        tb_CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [10:0] LEN = '0;
    logic [31:0] DOUT;
    logic        DOUT_VALID;
    logic        DOUT_READY = 1'b0;
    logic        DOUT_LAST;
    logic        BUSY;
    logic        DONE;
`ifdef OBI_DUMP_CHECKSUM_EN
    logic [31:0] CHECKSUM;
`endif

    obi_intf obi ();

    obi_mem_dump dut (
        .CLK          (tb_CLK),
        .RST          (RST),
        .START        (START),
        .LEN          (LEN),
        .obi_intf_out (obi),
        .DOUT         (DOUT),
        .DOUT_VALID   (DOUT_VALID),
        .DOUT_READY   (DOUT_READY),
        .DOUT_LAST    (DOUT_LAST),
        .BUSY         (BUSY),
        .DONE         (DONE)
`ifdef OBI_DUMP_CHECKSUM_EN
        ,
        .CHECKSUM     (CHECKSUM)
`endif
    );

    always #5 tb_CLK = ~tb_CLK;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] mem [1024];
    int          gnt_delay_cfg = 0;
    int          rsp_delay_cfg = 0;
    bit          rand_ready = 1'b0;
    time         stall_until = 0;

    bit          waiting = 1'b0;
    bit          rsp_pending = 1'b0;
    int          gwait = 0;
    int          rwait = 0;
    logic [31:0] rsp_data = '0;
    logic [31:0] hold_addr = '0;
    logic [31:0] got_data [$];
    bit          got_last [$];
    time         hs_time [$];
    logic [31:0] grant_addr [$];
    int          done_cnt = 0;
    time         done_time = 0;
    int          req_cycles = 0;
    int          addr_unstable = 0;
    int          overlap = 0;
    int          granted_cnt = 0;
    int          accepted_cnt = 0;
    int          max_inflight = 0;

    // Sink and SSRAM responder, evaluated mid-cycle so DUT outputs are settled.
    always @(negedge tb_CLK) begin
        if ($time < stall_until) DOUT_READY = 1'b0;
        else DOUT_READY = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (granted_cnt - accepted_cnt > max_inflight) max_inflight = granted_cnt - accepted_cnt;
        if (DOUT_VALID && DOUT_READY) begin
            got_data.push_back(DOUT);
            got_last.push_back(DOUT_LAST);
            hs_time.push_back($time);
            accepted_cnt++;
        end
        if (DONE) begin
            done_cnt++;
            done_time = $time;
        end
        obi.rvalid = 1'b0;
        obi.rdata  = '0;
        if (rsp_pending) begin
            if (rwait == 0) begin
                obi.rvalid  = 1'b1;
                obi.rdata   = rsp_data;
                rsp_pending = 1'b0;
            end else begin
                rwait--;
            end
        end
        obi.gnt = 1'b0;
        if (obi.req === 1'b1) begin
            req_cycles++;
            if (rsp_pending) overlap++;
            if (!waiting) begin
                waiting   = 1'b1;
                hold_addr = obi.addr;
                gwait     = (gnt_delay_cfg < 0) ? int'($urandom_range(0, 3)) : gnt_delay_cfg;
            end else if (obi.addr !== hold_addr) begin
                addr_unstable++;
            end
            if (gwait == 0) begin
                obi.gnt     = 1'b1;
                waiting     = 1'b0;
                grant_addr.push_back(obi.addr);
                rsp_data    = mem[obi.addr[11:2]];
                rsp_pending = 1'b1;
                rwait       = (rsp_delay_cfg < 0) ? int'($urandom_range(0, 4)) : rsp_delay_cfg;
                granted_cnt++;
            end else begin
                gwait--;
            end
        end else begin
            waiting = 1'b0;
        end
    end

    task automatic applyStimulus(input int len);
        @(negedge tb_CLK);
        START = 1'b1;
        LEN   = 11'(len);
        @(negedge tb_CLK);
        START = 1'b0;
        LEN   = '0;
    endtask

    task automatic wait_done(input int base_done, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge tb_CLK);
            if (done_cnt > base_done) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge tb_CLK);
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) @(negedge tb_CLK);
        RST = 1'b0;
        @(negedge tb_CLK);
        checks++;
        if ({obi.req, obi.we, obi.be, DOUT_VALID, DOUT_LAST, BUSY, DONE} !== 10'b00_1111_0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: req,we,be,valid,last,busy,done=%b expected 0011110000",
                     {obi.req, obi.we, obi.be, DOUT_VALID, DOUT_LAST, BUSY, DONE});
        end
        checks++;
        if ({obi.addr, obi.wdata, DOUT} !== 96'h0) begin
            errors++;
            $display("[TB] FAIL reset_data: addr=%h wdata=%h dout=%h expected all zero", obi.addr, obi.wdata, DOUT);
        end
    endtask

    task automatic test_sequential();
        int bw, bg, bd, bad_gap;
        bit ok;
        gnt_delay_cfg = 0; rsp_delay_cfg = 0; rand_ready = 1'b0;
        for (int k = 0; k < 12; k++) mem[k] = 32'h1000_0000 + 32'(k);
        bw = got_data.size(); bg = grant_addr.size(); bd = done_cnt;
        applyStimulus(12);
        checks++;
        if ({BUSY, obi.req} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL seq_start: busy,req=%b expected 11", {BUSY, obi.req});
        end
        wait_done(bd, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL seq_timeout: done not seen, expected within budget"); end
        checks++;
        if (got_data.size() - bw != 12) begin
            errors++;
            $display("[TB] FAIL seq_count: got %0d words expected 12", got_data.size() - bw);
        end
        for (int k = 0; k < 12 && bw + k < got_data.size(); k++) begin
            checks++;
            if (got_data[bw+k] !== 32'h1000_0000 + 32'(k) || got_last[bw+k] !== (k == 11)) begin
                errors++;
                $display("[TB] FAIL seq_word%0d: data=%h last=%0b expected %h last=%0b",
                         k, got_data[bw+k], got_last[bw+k], 32'h1000_0000 + 32'(k), k == 11);
            end
        end
        for (int k = 0; k < 12 && bg + k < grant_addr.size(); k++) begin
            checks++;
            if (grant_addr[bg+k] !== 32'(4 * k)) begin
                errors++;
                $display("[TB] FAIL seq_addr%0d: addr=%h expected %h", k, grant_addr[bg+k], 32'(4 * k));
            end
        end
        checks++;
        if (hs_time.size() == 0 || done_time - hs_time[hs_time.size()-1] != 10) begin
            errors++;
            $display("[TB] FAIL seq_done_timing: done at %0t expected one cycle after last handshake", done_time);
        end
        bad_gap = 0;
        for (int k = bw + 1; k < hs_time.size(); k++) if (hs_time[k] - hs_time[k-1] != 20) bad_gap++;
        checks++;
        if (bad_gap != 0) begin
            errors++;
            $display("[TB] FAIL seq_throughput: %0d gaps differ, expected every gap 2 cycles", bad_gap);
        end
        checks++;
        if (done_cnt - bd != 1) begin
            errors++;
            $display("[TB] FAIL seq_done_count: got %0d pulses expected 1", done_cnt - bd);
        end
    endtask

    task automatic test_slow_obi();
        int bw, bg, bd, bu, bo;
        bit ok;
        gnt_delay_cfg = 3; rsp_delay_cfg = 4; rand_ready = 1'b0;
        for (int k = 0; k < 12; k++) mem[k] = $urandom();
        bw = got_data.size(); bg = grant_addr.size(); bd = done_cnt; bu = addr_unstable; bo = overlap;
        applyStimulus(12);
        wait_done(bd, ok);
        checks++;
        if (!ok || got_data.size() - bw != 12 || grant_addr.size() - bg != 12) begin
            errors++;
            $display("[TB] FAIL slow_count: done=%0b words=%0d grants=%0d expected 1/12/12",
                     ok, got_data.size() - bw, grant_addr.size() - bg);
        end
        for (int k = 0; k < 12 && bw + k < got_data.size(); k++) begin
            checks++;
            if (got_data[bw+k] !== mem[k]) begin
                errors++;
                $display("[TB] FAIL slow_word%0d: data=%h expected %h", k, got_data[bw+k], mem[k]);
            end
        end
        checks++;
        if (addr_unstable - bu != 0 || overlap - bo != 0) begin
            errors++;
            $display("[TB] FAIL slow_protocol: unstable=%0d overlap=%0d expected 0/0", addr_unstable - bu, overlap - bo);
        end
    endtask

    task automatic test_backpressure();
        int bw, bd, snap;
        bit ok;
        gnt_delay_cfg = 0; rsp_delay_cfg = 0; rand_ready = 1'b0;
        for (int k = 0; k < 12; k++) mem[k] = $urandom();
        bw = got_data.size(); bd = done_cnt;
        applyStimulus(12);
        for (int c = 0; c < 200 && got_data.size() - bw < 3; c++) @(negedge tb_CLK);
        stall_until = $time + 100;
        @(negedge tb_CLK);
        snap = got_data.size();
        repeat (7) @(negedge tb_CLK);
        checks++;
        if ({obi.req, DOUT_VALID} !== 2'b01 || got_data.size() != snap) begin
            errors++;
            $display("[TB] FAIL bp_stall: req,valid=%b accepted=%0d expected 01 and 0 accepted",
                     {obi.req, DOUT_VALID}, got_data.size() - snap);
        end
        wait_done(bd, ok);
        checks++;
        if (!ok || got_data.size() - bw != 12) begin
            errors++;
            $display("[TB] FAIL bp_count: done=%0b words=%0d expected 1/12", ok, got_data.size() - bw);
        end
        for (int k = 0; k < 12 && bw + k < got_data.size(); k++) begin
            checks++;
            if (got_data[bw+k] !== mem[k]) begin
                errors++;
                $display("[TB] FAIL bp_word%0d: data=%h expected %h", k, got_data[bw+k], mem[k]);
            end
        end
        checks++;
        if (max_inflight > 2) begin
            errors++;
            $display("[TB] FAIL bp_inflight: max buffered+outstanding=%0d expected <=2", max_inflight);
        end
    endtask

    task automatic test_len_zero();
        int bd, br;
        bd = done_cnt; br = req_cycles;
        applyStimulus(0);
        checks++;
        if ({DONE, BUSY} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL zero_done: done,busy=%b expected 10", {DONE, BUSY});
        end
        repeat (5) @(negedge tb_CLK);
        checks++;
        if (req_cycles != br || done_cnt - bd != 1) begin
            errors++;
            $display("[TB] FAIL zero_traffic: req cycles=%0d done pulses=%0d expected 0/1", req_cycles - br, done_cnt - bd);
        end
    endtask

    task automatic test_start_while_busy();
        int bw, bd;
        bit ok;
        gnt_delay_cfg = 1; rsp_delay_cfg = 1; rand_ready = 1'b0;
        for (int k = 0; k < 6; k++) mem[k] = $urandom();
        bw = got_data.size(); bd = done_cnt;
        applyStimulus(6);
        repeat (3) @(negedge tb_CLK);
        START = 1'b1; LEN = 11'd3;
        @(negedge tb_CLK);
        START = 1'b0; LEN = '0;
        wait_done(bd, ok);
        checks++;
        if (!ok || got_data.size() - bw != 6 || done_cnt - bd != 1) begin
            errors++;
            $display("[TB] FAIL busy_start: done=%0b words=%0d pulses=%0d expected 1/6/1", ok, got_data.size() - bw, done_cnt - bd);
        end
        for (int k = 0; k < 6 && bw + k < got_data.size(); k++) begin
            checks++;
            if (got_data[bw+k] !== mem[k] || got_last[bw+k] !== (k == 5)) begin
                errors++;
                $display("[TB] FAIL busy_word%0d: data=%h last=%0b expected %h last=%0b",
                         k, got_data[bw+k], got_last[bw+k], mem[k], k == 5);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bw, bd;
        bit ok;
        gnt_delay_cfg = 6; rsp_delay_cfg = 0; rand_ready = 1'b0;
        applyStimulus(5);
        checks++;
        if (obi.req !== 1'b1) begin errors++; $display("[TB] FAIL rst_pre: req=%b expected 1", obi.req); end
        RST = 1'b1;
        @(negedge tb_CLK);
        RST = 1'b0;
        checks++;
        if ({obi.req, obi.we, obi.be, DOUT_VALID, DOUT_LAST, BUSY, DONE} !== 10'b00_1111_0000 ||
            {obi.addr, obi.wdata, DOUT} !== 96'h0) begin
            errors++;
            $display("[TB] FAIL rst_mid: ctrl=%b addr=%h dout=%h expected 0011110000/0/0",
                     {obi.req, obi.we, obi.be, DOUT_VALID, DOUT_LAST, BUSY, DONE}, obi.addr, DOUT);
        end
        repeat (8) @(negedge tb_CLK);
        gnt_delay_cfg = 0;
        mem[0] = $urandom(); mem[1] = $urandom();
        bw = got_data.size(); bd = done_cnt;
        applyStimulus(2);
        wait_done(bd, ok);
        checks++;
        if (!ok || got_data.size() - bw != 2) begin
            errors++;
            $display("[TB] FAIL rst_resume: done=%0b words=%0d expected 1/2", ok, got_data.size() - bw);
        end else begin
            checks++;
            if (got_data[bw] !== mem[0] || got_data[bw+1] !== mem[1] || {got_last[bw], got_last[bw+1]} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL rst_words: %h %h last=%b%b expected %h %h last=01",
                         got_data[bw], got_data[bw+1], got_last[bw], got_last[bw+1], mem[0], mem[1]);
            end
        end
    endtask

    task automatic test_random();
        int bw, bg, bd, bu, bo, len, bad;
        bit ok;
        logic [31:0] sum;
        gnt_delay_cfg = -1; rsp_delay_cfg = -1; rand_ready = 1'b1;
        for (int it = 0; it < 3; it++) begin
            len = $urandom_range(1, 24);
            sum = '0;
            for (int k = 0; k < len; k++) begin
                mem[k] = $urandom();
                sum    = sum + mem[k];
            end
            bw = got_data.size(); bg = grant_addr.size(); bd = done_cnt; bu = addr_unstable; bo = overlap;
            applyStimulus(len);
            wait_done(bd, ok);
            checks++;
            if (!ok || got_data.size() - bw != len || done_cnt - bd != 1) begin
                errors++;
                $display("[TB] FAIL rand%0d_count: done=%0b words=%0d pulses=%0d expected 1/%0d/1",
                         it, ok, got_data.size() - bw, done_cnt - bd, len);
            end
            bad = 0;
            for (int k = 0; k < len && bw + k < got_data.size(); k++) begin
                if (got_data[bw+k] !== mem[k] || got_last[bw+k] !== (k == len - 1)) bad++;
                if (bg + k < grant_addr.size() && grant_addr[bg+k] !== 32'(4 * k)) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL rand%0d_words: %0d word/last/addr differences expected 0", it, bad);
            end
            checks++;
            if (addr_unstable - bu != 0 || overlap - bo != 0 || max_inflight > 2) begin
                errors++;
                $display("[TB] FAIL rand%0d_protocol: unstable=%0d overlap=%0d inflight=%0d expected 0/0/<=2",
                         it, addr_unstable - bu, overlap - bo, max_inflight);
            end
`ifdef OBI_DUMP_CHECKSUM_EN
            checks++;
            if (CHECKSUM !== sum) begin
                errors++;
                $display("[TB] FAIL rand%0d_checksum: got %h expected %h", it, CHECKSUM, sum);
            end
`endif
        end
        rand_ready = 1'b0;
    endtask

`ifdef OBI_DUMP_CHECKSUM_EN
    task automatic test_checksum();
        int bd;
        bit ok;
        gnt_delay_cfg = 0; rsp_delay_cfg = 0; rand_ready = 1'b0;
        mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h0000_0002;
        bd = done_cnt;
        applyStimulus(2);
        wait_done(bd, ok);
        checks++;
        if (!ok || CHECKSUM !== 32'h0000_0001) begin
            errors++;
            $display("[TB] FAIL checksum_wrap: done=%0b sum=%h expected 1/00000001", ok, CHECKSUM);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_sequential();
        test_slow_obi();
        test_backpressure();
        test_len_zero();
        test_start_while_busy();
        test_reset_mid();
        test_random();
`ifdef OBI_DUMP_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
